// File: rtl/axum_xbus_pkg.sv
// Shared types and helpers for the axum multi-host interconnect.
package axum_xbus_pkg;

    typedef enum logic {
        XBUS_IDLE = 1'b0,
        XBUS_WAIT = 1'b1
    } xbus_state_e;

    // Index width for N ports; a single port still needs one bit.
    function automatic int unsigned xbus_idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axum_xbus_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, registered rotating start pointer.
module axum_rr_arbiter
    import axum_xbus_pkg::*;
#(
    parameter  int unsigned N  = 2,
    localparam int unsigned IW = xbus_idx_w(N)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [N-1:0]  req_i,
    input  logic          en_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] cand;
    logic [IW-1:0] win;
    logic          found;

    // Scan from the pointer upward with wrap; first requester wins.
    always_comb begin
        cand  = '0;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IW'((32'(ptr_q) + k) % N);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        gnt_o   = '0;
        valid_o = en_i && found;
        idx_o   = win;
        ptr_d   = ptr_q;
        if (valid_o) begin
            gnt_o[win] = 1'b1;
            ptr_d      = IW'((32'(win) + 1) % N);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/axum_xbus.sv
// Multi-host memory-mapped interconnect, one outstanding transaction at a time.
// Optional response timeout enabled by defining AXUM_XBUS_TIMEOUT_EN.
module axum_xbus
    import axum_xbus_pkg::*;
#(
    parameter int unsigned NrHosts       = 2,
    parameter int unsigned NrDevices     = 5,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned AddressWidth  = 32,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic [NrHosts-1:0]                        host_req_i,
    input  logic [NrHosts-1:0]                        host_we_i,
    input  logic [NrHosts-1:0][AddressWidth-1:0]      host_addr_i,
    input  logic [NrHosts-1:0][DataWidth/8-1:0]       host_be_i,
    input  logic [NrHosts-1:0][DataWidth-1:0]         host_wdata_i,
    output logic [NrHosts-1:0]                        host_gnt_o,
    output logic [NrHosts-1:0]                        host_rvalid_o,
    output logic [NrHosts-1:0]                        host_err_o,
    output logic [NrHosts-1:0][DataWidth-1:0]         host_rdata_o,
    output logic [NrDevices-1:0]                      device_req_o,
    output logic [NrDevices-1:0]                      device_we_o,
    output logic [NrDevices-1:0][AddressWidth-1:0]    device_addr_o,
    output logic [NrDevices-1:0][DataWidth/8-1:0]     device_be_o,
    output logic [NrDevices-1:0][DataWidth-1:0]       device_wdata_o,
    input  logic [NrDevices-1:0]                      device_rvalid_i,
    input  logic [NrDevices-1:0]                      device_err_i,
    input  logic [NrDevices-1:0][DataWidth-1:0]       device_rdata_i,
    input  logic [NrDevices-1:0][AddressWidth-1:0]    cfg_device_addr_base,
    input  logic [NrDevices-1:0][AddressWidth-1:0]    cfg_device_addr_mask
);

    localparam int unsigned HW  = xbus_idx_w(NrHosts);
    localparam int unsigned DIW = xbus_idx_w(NrDevices);

    if (NrHosts == 0 || NrDevices == 0 || TimeoutCycles < 2) begin : g_bad_cfg
        $error("axum_xbus: invalid parameter set");
    end

    xbus_state_e    state_q;
    logic [HW-1:0]  host_q;
    logic [DIW-1:0] dev_q;
    logic           dec_err_q;

    logic                    grant;
    logic [HW-1:0]           win_idx;
    logic [AddressWidth-1:0] win_addr;
    logic                    hit;
    logic [DIW-1:0]          dev_idx;
    logic                    resp_done;

`ifdef AXUM_XBUS_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TimeoutCycles + 1);
    logic [CW-1:0] tmo_q;
`endif

    axum_rr_arbiter #(.N(NrHosts)) u_arb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (host_req_i),
        .en_i    ((state_q == XBUS_IDLE) && !rst_i),
        .gnt_o   (host_gnt_o),
        .idx_o   (win_idx),
        .valid_o (grant)
    );

    assign win_addr = host_addr_i[win_idx];

    // Scan downward so the lowest-index matching device is the one kept.
    always_comb begin
        hit     = 1'b0;
        dev_idx = '0;
        for (int d = int'(NrDevices) - 1; d >= 0; d--) begin
            if ((win_addr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]) begin
                hit     = 1'b1;
                dev_idx = DIW'(d);
            end
        end
    end

    always_comb begin
        device_req_o = '0;
        if (grant && hit) begin
            device_req_o[dev_idx] = 1'b1;
        end
        for (int d = 0; d < int'(NrDevices); d++) begin
            device_we_o[d]    = grant ? host_we_i[win_idx]    : 1'b0;
            device_addr_o[d]  = grant ? win_addr              : '0;
            device_be_o[d]    = grant ? host_be_i[win_idx]    : '0;
            device_wdata_o[d] = grant ? host_wdata_i[win_idx] : '0;
        end
    end

    // Only the selected device can complete the transaction; anything else is dropped.
    always_comb begin
        host_rvalid_o = '0;
        host_err_o    = '0;
        host_rdata_o  = '0;
        resp_done     = 1'b0;
        if (state_q == XBUS_WAIT && !rst_i) begin
            if (dec_err_q) begin
                resp_done             = 1'b1;
                host_rvalid_o[host_q] = 1'b1;
                host_err_o[host_q]    = 1'b1;
            end else if (device_rvalid_i[dev_q]) begin
                resp_done             = 1'b1;
                host_rvalid_o[host_q] = 1'b1;
                host_err_o[host_q]    = device_err_i[dev_q];
                host_rdata_o[host_q]  = device_rdata_i[dev_q];
            end
`ifdef AXUM_XBUS_TIMEOUT_EN
            else if (tmo_q == CW'(TimeoutCycles - 1)) begin
                resp_done             = 1'b1;
                host_rvalid_o[host_q] = 1'b1;
                host_err_o[host_q]    = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= XBUS_IDLE;
            host_q    <= '0;
            dev_q     <= '0;
            dec_err_q <= 1'b0;
`ifdef AXUM_XBUS_TIMEOUT_EN
            tmo_q     <= '0;
`endif
        end else begin
            case (state_q)
                XBUS_IDLE: begin
                    if (grant) begin
                        state_q   <= XBUS_WAIT;
                        host_q    <= win_idx;
                        dev_q     <= dev_idx;
                        dec_err_q <= !hit;
`ifdef AXUM_XBUS_TIMEOUT_EN
                        tmo_q     <= '0;
`endif
                    end
                end
                XBUS_WAIT: begin
                    if (resp_done) begin
                        state_q <= XBUS_IDLE;
                    end
`ifdef AXUM_XBUS_TIMEOUT_EN
                    else begin
                        tmo_q <= tmo_q + CW'(1);
                    end
`endif
                end
                default: state_q <= XBUS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axum_xbus.sv
// Directed bench for axum_xbus: 2 hosts, 5 devices, TimeoutCycles=4.
module tb_axum_xbus;

    localparam int NH = 2;
    localparam int ND = 5;

    logic                   clk = 1'b0;
    logic                   rst_i;
    logic [NH-1:0]          host_req_i, host_we_i;
    logic [NH-1:0][31:0]    host_addr_i;
    logic [NH-1:0][3:0]     host_be_i;
    logic [NH-1:0][31:0]    host_wdata_i;
    logic [NH-1:0]          host_gnt_o, host_rvalid_o, host_err_o;
    logic [NH-1:0][31:0]    host_rdata_o;
    logic [ND-1:0]          device_req_o, device_we_o;
    logic [ND-1:0][31:0]    device_addr_o;
    logic [ND-1:0][3:0]     device_be_o;
    logic [ND-1:0][31:0]    device_wdata_o;
    logic [ND-1:0]          device_rvalid_i, device_err_i;
    logic [ND-1:0][31:0]    device_rdata_i;
    logic [ND-1:0][31:0]    cfg_base, cfg_mask;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    axum_xbus #(
        .NrHosts(NH), .NrDevices(ND), .DataWidth(32), .AddressWidth(32), .TimeoutCycles(4)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .host_req_i(host_req_i), .host_we_i(host_we_i), .host_addr_i(host_addr_i),
        .host_be_i(host_be_i), .host_wdata_i(host_wdata_i),
        .host_gnt_o(host_gnt_o), .host_rvalid_o(host_rvalid_o), .host_err_o(host_err_o),
        .host_rdata_o(host_rdata_o),
        .device_req_o(device_req_o), .device_we_o(device_we_o), .device_addr_o(device_addr_o),
        .device_be_o(device_be_o), .device_wdata_o(device_wdata_o),
        .device_rvalid_i(device_rvalid_i), .device_err_i(device_err_i),
        .device_rdata_i(device_rdata_i),
        .cfg_device_addr_base(cfg_base), .cfg_device_addr_mask(cfg_mask)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic seen;
        rst_i           = 1'b1;
        host_req_i      = '1;
        host_we_i       = '0;
        host_addr_i     = '0;
        host_be_i       = '1;
        host_wdata_i    = '0;
        device_rvalid_i = '0;
        device_err_i    = '0;
        device_rdata_i  = '0;
        cfg_base[0] = 32'h0010_0000; cfg_mask[0] = 32'hFFFF_C000;
        cfg_base[1] = 32'h0002_0000; cfg_mask[1] = 32'hFFFF_0000;
        cfg_base[2] = 32'h0003_0000; cfg_mask[2] = 32'hFFFF_F000;
        cfg_base[3] = 32'h0002_0000; cfg_mask[3] = 32'hFFFE_0000;
        cfg_base[4] = 32'h0004_0000; cfg_mask[4] = 32'hFFFF_F000;

        // Reset: all outputs quiet even with requests pending
        tick(); #1;
        chk("rst_gnt", 64'(host_gnt_o), 0);
        chk("rst_rvalid", 64'(host_rvalid_o), 0);
        chk("rst_dreq", 64'(device_req_o), 0);
        chk("rst_daddr", 64'(device_addr_o[0]), 0);

        // Single read from RAM
        tick();
        rst_i = 1'b0; host_req_i = 2'b01; host_addr_i[0] = 32'h0010_0010; #1;
        chk("rd_gnt", 64'(host_gnt_o), 64'b01);
        chk("rd_dreq", 64'(device_req_o), 64'b00001);
        chk("rd_daddr", 64'(device_addr_o[0]), 64'h0010_0010);
        tick();
        host_req_i = '0; device_rvalid_i = 5'b00001; device_rdata_i[0] = 32'hDEAD_BEEF; #1;
        chk("rd_rvalid", 64'(host_rvalid_o), 64'b01);
        chk("rd_rdata", 64'(host_rdata_o[0]), 64'hDEAD_BEEF);
        chk("rd_rdata_h1", 64'(host_rdata_o[1]), 0);
        chk("rd_err", 64'(host_err_o), 0);

        // Unmapped write from host1
        tick();
        device_rvalid_i = '0; host_req_i = 2'b10; host_we_i = 2'b10; host_addr_i[1] = 32'h0000_0004; #1;
        chk("um_gnt", 64'(host_gnt_o), 64'b10);
        chk("um_dreq", 64'(device_req_o), 0);
        tick();
        host_req_i = '0; host_we_i = '0; #1;
        chk("um_rvalid", 64'(host_rvalid_o), 64'b10);
        chk("um_err", 64'(host_err_o), 64'b10);
        chk("um_rdata", 64'(host_rdata_o[1]), 0);

        // Overlapping devices 1 and 3: device 1 wins
        tick();
        host_req_i = 2'b01; host_addr_i[0] = 32'h0002_0000; #1;
        chk("ov_dreq", 64'(device_req_o), 64'b00010);
        tick();
        host_req_i = '0; device_rvalid_i = 5'b01010;
        device_rdata_i[1] = 32'h1111_2222; device_rdata_i[3] = 32'h3333_4444; #1;
        chk("ov_rvalid", 64'(host_rvalid_o), 64'b01);
        chk("ov_rdata", 64'(host_rdata_o[0]), 64'h1111_2222);

        // Wrong-device response dropped; no grant while waiting
        tick();
        device_rvalid_i = '0; host_req_i = 2'b10; host_addr_i[1] = 32'h0010_0020; #1;
        chk("wd_gnt", 64'(host_gnt_o), 64'b10);
        tick();
        host_req_i = 2'b01; host_addr_i[0] = 32'h0010_0000; device_rvalid_i = 5'b00100; #1;
        chk("wd_gnt_wait", 64'(host_gnt_o), 0);
        chk("wd_rvalid", 64'(host_rvalid_o), 0);
        tick();
        device_rvalid_i = 5'b00001; device_rdata_i[0] = 32'hCAFE_F00D; #1;
        chk("wd_rvalid2", 64'(host_rvalid_o), 64'b10);
        chk("wd_rdata", 64'(host_rdata_o[1]), 64'hCAFE_F00D);
        chk("wd_gnt_wait2", 64'(host_gnt_o), 0);
        tick();
        device_rvalid_i = '0; #1;
        chk("wd_pending_gnt", 64'(host_gnt_o), 64'b01);
        tick();
        host_req_i = '0; device_rvalid_i = 5'b00001; #1;
        chk("wd_pending_rv", 64'(host_rvalid_o), 64'b01);

        // Response while Idle is dropped
        tick(); #1;
        chk("idle_rvalid", 64'(host_rvalid_o), 0);
        chk("idle_rdata", 64'(host_rdata_o[0]), 0);

        // Contention from reset: grants alternate h0,h1 every 2 cycles
        rst_i = 1'b1; device_rvalid_i = '0;
        tick();
        rst_i = 1'b0; host_req_i = 2'b11;
        host_addr_i[0] = 32'h0010_0000; host_addr_i[1] = 32'h0010_0004;
        device_rvalid_i = 5'b00001; device_rdata_i[0] = 32'h5A5A_0000;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (i % 2 == 0) begin
                chk($sformatf("ct_gnt%0d", i), 64'(host_gnt_o), ((i / 2) % 2 == 0) ? 64'b01 : 64'b10);
                chk($sformatf("ct_rv%0d", i), 64'(host_rvalid_o), 0);
            end else begin
                chk($sformatf("ct_gnt%0d", i), 64'(host_gnt_o), 0);
                chk($sformatf("ct_rv%0d", i), 64'(host_rvalid_o), ((i / 2) % 2 == 0) ? 64'b01 : 64'b10);
            end
            tick();
        end
        host_req_i = '0; device_rvalid_i = '0;

        // Reset asserted in the first Wait cycle
        host_req_i = 2'b01; #1;
        chk("rm_gnt", 64'(host_gnt_o), 64'b01);
        tick();
        host_req_i = '0; rst_i = 1'b1; device_rvalid_i = 5'b00001; #1;
        chk("rm_rv_in_rst", 64'(host_rvalid_o), 0);
        tick();
        rst_i = 1'b0; #1;
        chk("rm_rv_late", 64'(host_rvalid_o), 0);
        chk("rm_rdata_late", 64'(host_rdata_o[0]), 0);
        chk("rm_gnt_idle", 64'(host_gnt_o), 0);
        chk("rm_dreq_idle", 64'(device_req_o), 0);
        tick();
        device_rvalid_i = '0; host_req_i = 2'b11; #1;
        chk("rm_first_gnt", 64'(host_gnt_o), 64'b01);
        tick();
        host_req_i = '0; device_rvalid_i = 5'b00001; #1;
        chk("rm_resp", 64'(host_rvalid_o), 64'b01);
        tick();
        device_rvalid_i = '0;

        // Silent device (GPIO)
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0; host_req_i = 2'b01; host_addr_i[0] = 32'h0003_0000; #1;
        chk("to_dreq", 64'(device_req_o), 64'b00100);
        tick();
        host_req_i = '0;
`ifdef AXUM_XBUS_TIMEOUT_EN
        for (int c = 1; c < 4; c++) begin
            #1;
            chk($sformatf("to_quiet%0d", c), 64'(host_rvalid_o), 0);
            tick();
        end
        #1;
        chk("to_rvalid", 64'(host_rvalid_o), 64'b01);
        chk("to_err", 64'(host_err_o), 64'b01);
        chk("to_rdata", 64'(host_rdata_o[0]), 0);
        tick();
        host_req_i = 2'b10; host_addr_i[1] = 32'h0010_0000; device_rvalid_i = 5'b00100; #1;
        chk("to_next_gnt", 64'(host_gnt_o), 64'b10);
        chk("to_late_rv", 64'(host_rvalid_o), 0);
        tick();
        host_req_i = '0; device_rvalid_i = 5'b00101; device_rdata_i[0] = 32'h1234_5678; #1;
        chk("to_after_rv", 64'(host_rvalid_o), 64'b10);
        chk("to_after_rdata", 64'(host_rdata_o[1]), 64'h1234_5678);
        tick();
        device_rvalid_i = '0;
`else
        seen = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            #1;
            if (host_rvalid_o != '0) seen = 1'b1;
            tick();
        end
        chk("no_timeout", 64'(seen), 0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/axum_xbus.md
# axum_xbus

Multi-host, multi-device memory-mapped interconnect for the axum SoC. It replaces the single-host bus so that a second host, such as a DMA engine or debug module, can share the device fabric with the core data port. It adds round-robin host arbitration, explicit decode-error responses for unmapped addresses, and an optional response timeout. It sits between the hosts and the RAM/GPIO/timer/UART/register-file devices, using the same request/grant/rvalid protocol and base/mask address map.

## Interface
- NrHosts, 2, number of host ports (≥1)
- NrDevices, 5, number of device ports (≥1)
- DataWidth, 32, data bus width
- AddressWidth, 32, address bus width
- TimeoutCycles, 255, response timeout in cycles (used only with AXUM_XBUS_TIMEOUT_EN; ≥2)
- clk_i  in  1  single clock
- rst_i  in  1  reset; synchronous, active-high; all state cleared on the clk_i edge where rst_i=1
- host_req_i / host_we_i  in  [NrHosts] x 1  request, write enable
- host_addr_i  in  [NrHosts] x AddressWidth  byte address
- host_be_i  in  [NrHosts] x DataWidth/8  byte enables
- host_wdata_i  in  [NrHosts] x DataWidth  write data
- host_gnt_o / host_rvalid_o / host_err_o  out  [NrHosts] x 1  grant, response valid, error
- host_rdata_o  out  [NrHosts] x DataWidth  read data
- device_req_o / device_we_o  out  [NrDevices] x 1
- device_addr_o  out  [NrDevices] x AddressWidth
- device_be_o  out  [NrDevices] x DataWidth/8
- device_wdata_o  out  [NrDevices] x DataWidth
- device_rvalid_i / device_err_i  in  [NrDevices] x 1
- device_rdata_i  in  [NrDevices] x DataWidth
- cfg_device_addr_base / cfg_device_addr_mask  in  [NrDevices] x AddressWidth  device d matches when (addr & mask[d]) == base[d]

## Operation
- FSM states: Idle and Wait. Exactly one transaction is outstanding system-wide.
- Idle, arbitration:
  - If any host_req_i is set, the winner is the first requesting host scanning from rr_ptr upward, modulo NrHosts.
  - host_gnt_o[winner] is asserted combinationally in the same cycle.
  - rr_ptr becomes (winner+1) mod NrHosts.
  - The FSM registers the host index, the device index and a dec_err flag, then moves to Wait.
- Decode:
  - The lowest-index matching device wins.
  - device_req_o[dev] is asserted only in the grant cycle.
  - device_addr/we/be/wdata of all devices carry the winner's signals; they are zero when there is no grant.
- Decode miss: no device_req_o is asserted and dec_err is set.
- Wait, normal response: when device_rvalid_i[dev] is 1, host_rvalid_o[host] is 1, and host_rdata_o/host_err_o are routed from that device. The FSM returns to Idle.
- Wait, dec_err: in the first Wait cycle, host_rvalid_o=1, host_err_o=1 and host_rdata_o=0. The FSM returns to Idle.
- Responses outside Wait, or from a device other than the selected one, are discarded.
- host_rdata_o and host_err_o are 0 on every host whose host_rvalid_o is 0.
- No grant is issued while in Wait; requests stay pending until the FSM returns to Idle.

## Timing
- Reset: state=Idle, rr_ptr=0, timeout counter=0. Every output is 0 during and after reset until a request arrives.
- Grant to request: combinational, cycle 0.
- Earliest response: cycle 1, which is also the dec_err response cycle.
- Back-to-back throughput: one transaction per 2 cycles minimum.
- Reset asserted in Wait: the FSM aborts to Idle and no response is delivered. A late device_rvalid_i after reset is discarded.
- Simultaneous requests from all hosts after reset: grant order is 0, 1, …, NrHosts-1, 0, …
- A single persistent requester is regranted every second cycle regardless of rr_ptr.

## Configuration
- AXUM_XBUS_TIMEOUT_EN defined:
  - A counter of width $clog2(TimeoutCycles+1) clears on entry to Wait and increments each Wait cycle without a response.
  - If Wait reaches cycle TimeoutCycles after grant with no rvalid, the block returns host_rvalid_o=1, host_err_o=1, host_rdata_o=0 and goes to Idle.
  - A subsequent late rvalid from that device is discarded.
- Not defined: there is no counter, and Wait persists until the device responds. A silent device hangs the bus by design.

## Structure
- Package axum_xbus_pkg holds the xbus_state_e typedef (Idle, Wait) and the helper function computing the index width, max(1, $clog2(N)).
- Sub-module axum_rr_arbiter (parameter N) contains the request vector, enable, grant one-hot and registered rotating pointer. It is reusable for future DMA/IRQ arbitration.
- Decoder and response mux stay inline in axum_xbus.

## Test plan
- Single read: host0 reads 0x00100010, RAM base 0x100000, mask ~0x3FFF.
  - Cycle 0: gnt0=1 and device_req[0]=1 with addr 0x00100010.
  - Cycle 1: RAM returns rvalid with 0xDEADBEEF, giving host_rvalid_o[0]=1 and rdata 0xDEADBEEF.
- Contention: host0 and host1 request continuously from reset, devices respond at cycle 1. Grants alternate h0, h1, h0, h1 on cycles 0, 2, 4, 6.
- Unmapped address: host1 writes 0x00000004. No device_req_o is asserted; in cycle 1, host_rvalid_o[1]=1, host_err_o[1]=1, rdata=0.
- Overlap: two devices both match 0x20000 (indices 1 and 3). Only device_req_o[1] is asserted.
- Timeout: macro defined, TimeoutCycles=4, device never responds.
  - Err response arrives in cycle 4 and the next grant is possible in cycle 5.
  - A later rvalid from that device is ignored.
  - Without the macro, there is no response by cycle 100.
- Reset mid-operation: rst_i=1 in cycle 1 of Wait.
  - The next cycle is Idle with all outputs 0.
  - The device's rvalid in cycle 2 does not reach any host.
  - After reset, host0 is granted first.
